mdu_sequencer: RTL and testbench

- Multi-cycle sequencer for the RV32M multiply/divide unit (MDU).
- The controller's md_op_ctrl_o/mdu_op steer an instruction here.
- The block latches operands and runs an iterative shift-add multiply or restoring divide over 32 steps.
- It handles the divide special cases, applies sign correction and returns a tagged result to writeback while holding the pipeline busy.

---
 rtl/riscv_defines.sv | 25 ++
 rtl/mdu_iter_unit.sv | 59 +++++
 rtl/mdu_sequencer.sv | 167 ++++++++++++++++
 tb/tb_mdu_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
// Shared RV32M definitions: MDU operation encodings and the sequencer state type.
package riscv_defines;

  localparam int MDU_OP_WIDTH = 3;

  localparam logic [MDU_OP_WIDTH-1:0] MDU_MUL    = 3'd0;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MULH   = 3'd1;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHSU = 3'd2;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHU  = 3'd3;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_DIV    = 3'd4;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_DIVU   = 3'd5;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_REM    = 3'd6;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_e;

  function automatic logic op_is_div(input logic [MDU_OP_WIDTH-1:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input logic [MDU_OP_WIDTH-1:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/mdu_iter_unit.sv
// Datapath for the MDU: 64-bit accumulator with one shift-add (multiply)
// or one restoring subtract (divide) step per cycle.
module mdu_iter_unit
  import riscv_defines::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   m_q, m_d;
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_diff;

  assign acc_o = acc_q;

  // Multiply keeps {hi,multiplier}; divide keeps {remainder,quotient} and m holds the divisor.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}});
    div_diff = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, m_q};
    acc_d    = acc_q;
    m_d      = m_q;
    if (load) begin
      m_d   = is_div ? b_i : a_i;
      acc_d = {{XLEN{1'b0}}, (is_div ? a_i : b_i)};
    end else if (step) begin
      if (is_div) begin
        if (div_diff[XLEN+1]) begin
          acc_d = {acc_q[2*XLEN-2:0], 1'b0};
        end else begin
          acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
      end else begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
      end
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= {(2*XLEN){1'b0}};
      m_q   <= {XLEN{1'b0}};
    end else begin
      acc_q <= acc_d;
      m_q   <= m_d;
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// RV32M multi-cycle sequencer: accepts an MDU op, runs 32 iterations in
// mdu_iter_unit, applies sign correction and returns a tagged result.
module mdu_sequencer
  import riscv_defines::*;
#(
  parameter int XLEN   = 32,
  parameter int ITER_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_i,
  input  logic [MDU_OP_WIDTH-1:0] mdu_op_i,
  input  logic [XLEN-1:0]         op_a_i,
  input  logic [XLEN-1:0]         op_b_i,
  input  logic [4:0]              rd_i,
  input  logic                    kill_i,
  output logic                    ready_o,
  output logic                    busy_o,
  output logic                    result_valid_o,
  output logic [XLEN-1:0]         result_o,
  output logic [4:0]              result_rd_o
);

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e              state_q, state_d;
  logic [ITER_W-1:0]       cnt_q, cnt_d;
  logic [MDU_OP_WIDTH-1:0] op_q, op_d, op_n;
  logic [4:0]              rd_q, rd_d, result_rd_q, result_rd_d;
  logic                    sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [XLEN-1:0]         result_q, result_d;
  logic                    a_signed, b_signed, a_neg, b_neg;
  logic                    div_zero, div_ovf, special, accept;
  logic [XLEN-1:0]         a_mag, b_mag, special_res, fix_res, quot, rem;
  logic [2*XLEN-1:0]       acc, prod_fix;
  logic                    iter_load, iter_step, iter_is_div;

  assign ready_o        = (state_q == IDLE) || (state_q == DONE);
  assign busy_o         = (state_q == CALC) || (state_q == FIX);
  assign result_valid_o = (state_q == DONE) && !kill_i;
  assign result_o       = result_q;
  assign result_rd_o    = result_rd_q;
  assign accept         = valid_i && ready_o && !kill_i;

  // Decode the incoming op: signedness, magnitudes and divide special cases.
  always_comb begin
    case (mdu_op_i)
      MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU,
      MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU: op_n = mdu_op_i;
      default:                              op_n = MDU_MUL;
    endcase
    a_signed = (op_n == MDU_MULH) || (op_n == MDU_MULHSU) || (op_n == MDU_DIV) || (op_n == MDU_REM);
    b_signed = (op_n == MDU_MULH) || (op_n == MDU_DIV) || (op_n == MDU_REM);
    a_neg    = a_signed && op_a_i[XLEN-1];
    b_neg    = b_signed && op_b_i[XLEN-1];
    a_mag    = a_neg ? -op_a_i : op_a_i;
    b_mag    = b_neg ? -op_b_i : op_b_i;
    div_zero = op_is_div(op_n) && (op_b_i == {XLEN{1'b0}});
    div_ovf  = ((op_n == MDU_DIV) || (op_n == MDU_REM)) && (op_a_i == MIN_INT) && (op_b_i == ALL_ONES);
    special  = div_zero || div_ovf;
    if (div_zero) begin
      special_res = op_is_rem(op_n) ? op_a_i : ALL_ONES;
    end else if (div_ovf) begin
      special_res = op_is_rem(op_n) ? {XLEN{1'b0}} : MIN_INT;
    end else begin
      special_res = {XLEN{1'b0}};
    end
  end

  // Sign correction and result-word selection once the iterations are done.
  always_comb begin
    quot     = acc[XLEN-1:0];
    rem      = acc[2*XLEN-1:XLEN];
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc : acc;
    case (op_q)
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:               fix_res = (sign_a_q ^ sign_b_q) ? -quot : quot;
      MDU_REM, MDU_REMU:               fix_res = sign_a_q ? -rem : rem;
      default:                         fix_res = acc[XLEN-1:0];
    endcase
  end

  // Next-state logic; kill overrides everything including completion.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    rd_d        = rd_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    result_d    = result_q;
    result_rd_d = result_rd_q;
    if (kill_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            op_d     = op_n;
            rd_d     = rd_i;
            sign_a_d = a_neg;
            sign_b_d = b_neg;
            if (special) begin
              state_d     = DONE;
              result_d    = special_res;
              result_rd_d = rd_i;
            end else begin
              state_d = CALC;
              cnt_d   = {ITER_W{1'b0}};
            end
          end else begin
            state_d = IDLE;
          end
        end
        CALC: begin
          cnt_d   = cnt_q + {{(ITER_W-1){1'b0}}, 1'b1};
          state_d = (cnt_q == {ITER_W{1'b1}}) ? FIX : CALC;
        end
        FIX: begin
          result_d    = fix_res;
          result_rd_d = rd_q;
          state_d     = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign iter_load   = accept && !special;
  assign iter_step   = (state_q == CALC);
  assign iter_is_div = accept ? op_is_div(op_n) : op_is_div(op_q);

  mdu_iter_unit #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (iter_load),
    .step   (iter_step),
    .is_div (iter_is_div),
    .a_i    (a_mag),
    .b_i    (b_mag),
    .acc_o  (acc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= {ITER_W{1'b0}};
      op_q        <= MDU_MUL;
      rd_q        <= 5'd0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      result_q    <= {XLEN{1'b0}};
      result_rd_q <= 5'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      result_q    <= result_d;
      result_rd_q <= result_rd_d;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed scoreboard bench for mdu_sequencer: results, latency, busy time,
// divide special cases, kill and mid-op reset.
module tb_mdu_sequencer;
  import riscv_defines::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        kill_i = 1'b0;
  logic [2:0]  mdu_op_i = 3'd0;
  logic [31:0] op_a_i = 32'd0;
  logic [31:0] op_b_i = 32'd0;
  logic [4:0]  rd_i = 5'd0;
  logic        ready_o, busy_o, result_valid_o;
  logic [31:0] result_o;
  logic [4:0]  result_rd_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
  } exp_t;
  exp_t sb[$];

  logic [31:0] ta, tb_v;
  longint      p;
  int          q, r, seen;

  mdu_sequencer #(.XLEN(32), .ITER_W(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_i        (valid_i),
    .mdu_op_i       (mdu_op_i),
    .op_a_i         (op_a_i),
    .op_b_i         (op_b_i),
    .rd_i           (rd_i),
    .kill_i         (kill_i),
    .ready_o        (ready_o),
    .busy_o         (busy_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .result_rd_o    (result_rd_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input int lat);
    mdu_op_i = op;
    op_a_i   = a;
    op_b_i   = b;
    rd_i     = rd;
    valid_i  = 1'b1;
    sb.push_back('{rd: rd, res: res, lat: lat});
  endtask

  // k-th negedge after the accept edge corresponds to latency k
  task automatic wait_result(input string tag);
    int   got;
    int   busy_n;
    exp_t e;
    got    = 0;
    busy_n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      valid_i = 1'b0;
      if (busy_o) busy_n++;
      if (result_valid_o) begin
        got = k;
        break;
      end
    end
    e = sb.pop_front();
    check({tag, "_lat"}, 32'(got), 32'(e.lat));
    check({tag, "_res"}, result_o, e.res);
    check({tag, "_rd"}, 32'(result_rd_o), 32'(e.rd));
    check({tag, "_busy"}, 32'(busy_n), (e.lat == 34) ? 32'd33 : 32'd0);
  endtask

  task automatic no_strobe_window(input string tag);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (result_valid_o) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_valid", 32'(result_valid_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_rd", 32'(result_rd_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(MDU_MUL, 32'd7, 32'd6, 5'd5, 32'd42, 34);                   wait_result("mul_7x6");
    issue(MDU_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'h0, 34);     wait_result("mulh_m1");
    issue(MDU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFF, 34); wait_result("mulhsu_m1");
    issue(MDU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFE, 34);  wait_result("mulhu_max");

    ta   = 32'hDEADBEEF;
    tb_v = 32'h12345678;
    p    = longint'(signed'(ta)) * longint'(signed'(tb_v));
    issue(MDU_MULH, ta, tb_v, 5'd9, p[63:32], 34);                     wait_result("mulh_mix");
    issue(MDU_MUL, ta, tb_v, 5'd10, p[31:0], 34);                      wait_result("mul_mix");

    issue(MDU_DIV, 32'hFFFFFFF9, 32'd2, 5'd11, 32'hFFFFFFFD, 34);     wait_result("div_m7_2");
    issue(MDU_REM, 32'hFFFFFFF9, 32'd2, 5'd12, 32'hFFFFFFFF, 34);     wait_result("rem_m7_2");
    issue(MDU_DIVU, 32'd100, 32'd7, 5'd13, 32'd14, 34);               wait_result("divu_100_7");
    issue(MDU_REMU, 32'd100, 32'd7, 5'd14, 32'd2, 34);                wait_result("remu_100_7");

    ta = 32'hFFFFFC18;
    q  = -1000 / 37;
    r  = -1000 % 37;
    issue(MDU_DIV, ta, 32'd37, 5'd15, 32'(q), 34);                     wait_result("div_m1000_37");
    issue(MDU_REM, ta, 32'd37, 5'd16, 32'(r), 34);                     wait_result("rem_m1000_37");

    issue(MDU_DIVU, 32'd5, 32'd0, 5'd17, 32'hFFFFFFFF, 1);            wait_result("divu_by0");
    issue(MDU_REMU, 32'd5, 32'd0, 5'd18, 32'd5, 1);                   wait_result("remu_by0");
    issue(MDU_REM, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'd0, 1);      wait_result("rem_ovf");
    issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'h80000000, 1); wait_result("div_ovf");

    @(negedge clk);
    check("strobe_once", 32'(result_valid_o), 32'd0);
    check("idle_ready", 32'(ready_o), 32'd1);
    check("hold_result", result_o, 32'h80000000);
    check("hold_rd", 32'(result_rd_o), 32'd20);

    // kill on the 11th CALC cycle (iteration counter 10)
    mdu_op_i = MDU_MUL; op_a_i = 32'd3; op_b_i = 32'd4; rd_i = 5'd22; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    check("kill_pre_busy", 32'(busy_o), 32'd1);
    repeat (10) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    check("kill_ready", 32'(ready_o), 32'd1);
    check("kill_busy", 32'(busy_o), 32'd0);
    no_strobe_window("kill_no_strobe");
    check("kill_result_held", result_o, 32'h80000000);

    valid_i = 1'b1; kill_i = 1'b1; rd_i = 5'd23;
    @(negedge clk);
    valid_i = 1'b0; kill_i = 1'b0;
    check("valid_kill_busy", 32'(busy_o), 32'd0);
    no_strobe_window("valid_kill_no_strobe");

    // kill while DONE suppresses the strobe
    mdu_op_i = MDU_DIVU; op_a_i = 32'd5; op_b_i = 32'd0; rd_i = 5'd3; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    check("done_strobe_pre_kill", 32'(result_valid_o), 32'd1);
    kill_i = 1'b1;
    #1;
    check("done_kill_strobe", 32'(result_valid_o), 32'd0);
    @(negedge clk);
    kill_i = 1'b0;
    check("done_kill_idle", 32'(result_valid_o), 32'd0);

    // reset in the middle of CALC
    mdu_op_i = MDU_MUL; op_a_i = 32'd7; op_b_i = 32'd6; rd_i = 5'd24; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", 32'(ready_o), 32'd1);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_valid", 32'(result_valid_o), 32'd0);
    check("mid_rst_result", result_o, 32'd0);
    check("mid_rst_rd", 32'(result_rd_o), 32'd0);
    rst_n = 1'b1;
    no_strobe_window("mid_rst_no_strobe");

    issue(MDU_DIVU, 32'hFFFFFFFF, 32'd16, 5'd21, 32'h0FFFFFFF, 34);   wait_result("divu_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
